// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register addresses, field positions, exception codes, FSM states.
package cp0_pkg;

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  localparam int unsigned SR_IE_BIT     = 0;
  localparam int unsigned SR_EXL_BIT    = 1;
  localparam int unsigned SR_IM_LSB     = 10;
  localparam int unsigned SR_IM_MSB     = 15;
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_EXC_MSB = 6;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_IP_MSB  = 15;
  localparam int unsigned CAUSE_BD_BIT  = 31;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] PRID_DEFAULT       = 32'h2023_0707;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  // The state encoding doubles as SR.EXL.
  typedef enum logic {
    StRun     = 1'b0,
    StHandler = 1'b1
  } cp0_state_e;

endpackage

// File: rtl/cp0_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId plus trap/eret redirect requests.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT,
  parameter logic [31:0] PRID_VAL   = PRID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  cp0_addr,
  input  logic        cp0_we,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  m_exccode,
  input  logic [5:0]  hw_int,
  input  logic        m_eret,
  output logic        trap_req,
  output logic        eret_req,
  output logic [31:0] epc_out
);

  cp0_state_e  state_q, state_d;
  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic        sr_exl;
  logic        int_take;
  logic        exc_take;
  logic [31:0] trap_epc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign sr_exl   = (state_q == StHandler);
  assign int_take = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl;
  assign exc_take = (m_exccode != 5'd0) & ~sr_exl;
  assign trap_epc = m_bd ? (m_pc - 32'd4) : m_pc;
  assign epc_out  = epc_q;

  // Redirect requests; a trap in the same cycle masks eret, and reset masks both.
  always_comb begin
    trap_req = reset & (int_take | exc_take);
    eret_req = reset & m_eret & ~trap_req;
  end

  // Assemble architectural register images and the mfc0 read mux.
  always_comb begin
    sr_word                              = '0;
    sr_word[SR_IM_MSB:SR_IM_LSB]         = sr_im_q;
    sr_word[SR_EXL_BIT]                  = sr_exl;
    sr_word[SR_IE_BIT]                   = sr_ie_q;
    cause_word                           = '0;
    cause_word[CAUSE_BD_BIT]             = cause_bd_q;
    cause_word[CAUSE_IP_MSB:CAUSE_IP_LSB] = cause_ip_q;
    cause_word[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = cause_exc_q;
    unique case (cp0_addr)
      ADDR_SR:    cp0_rdata = sr_word;
      ADDR_CAUSE: cp0_rdata = cause_word;
      ADDR_EPC:   cp0_rdata = epc_q;
      ADDR_PRID:  cp0_rdata = PRID_VAL;
      default:    cp0_rdata = '0;
    endcase
  end

  // Next-state: trap update beats mtc0; eret clears EXL after any SR write.
  always_comb begin
    state_d     = state_q;
    sr_im_d     = sr_im_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    cause_ip_d  = hw_int;
    if (trap_req) begin
      state_d     = StHandler;
      cause_bd_d  = m_bd;
      cause_exc_d = int_take ? EXC_INT : m_exccode;
      epc_d       = {trap_epc[31:2], 2'b00};
    end else begin
      if (cp0_we) begin
        if (cp0_addr == ADDR_SR) begin
          sr_im_d = cp0_wdata[SR_IM_MSB:SR_IM_LSB];
          sr_ie_d = cp0_wdata[SR_IE_BIT];
          state_d = cp0_wdata[SR_EXL_BIT] ? StHandler : StRun;
        end else if (cp0_addr == ADDR_EPC) begin
          epc_d = {cp0_wdata[31:2], 2'b00};
        end
      end
      if (m_eret) begin
        state_d = StRun;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StRun;
      sr_im_q     <= '0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      state_q     <= state_d;
      sr_im_q     <= sr_im_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 Parameter HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry address.
REQ-002 Parameter PRID_VAL, 32'h2023_0707, constant read value of PRId.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low; asserted (0) at a rising edge resets all state.
REQ-005 cp0_addr  in  5  register select for read and write: 12 SR, 13 Cause, 14 EPC, 15 PRId.
REQ-006 cp0_we  in  1  mtc0 write strobe from the M stage.
REQ-007 cp0_wdata  in  32  mtc0 write data.
REQ-008 cp0_rdata  out  32  mfc0 read data, combinational from cp0_addr.
REQ-009 m_pc  in  32  PC of the instruction in the M stage.
REQ-010 m_bd  in  1  the M instruction sits in a branch delay slot.
REQ-011 m_exccode  in  5  exception code from the exception coder; 0 = no exception.
REQ-012 hw_int  in  6  external interrupt lines, level sensitive.
REQ-013 m_eret  in  1  eret in the M stage.
REQ-014 trap_req  out  1  flush the pipeline and redirect fetch to HANDLER_PC.
REQ-015 eret_req  out  1  flush the pipeline and redirect fetch to epc_out.
REQ-016 epc_out  out  32  current EPC value.

Function
REQ-017 SR fields: IM = [15:10], EXL = [1], IE = [0]; all other bits read 0.
REQ-018 Cause fields: BD = [31], IP = [15:10], ExcCode = [6:2]; all other bits read 0.
REQ-019 Cause.IP is loaded from hw_int every cycle, regardless of state.
REQ-020 int_take = |(hw_int & SR.IM) & SR.IE & ~SR.EXL; exc_take = (m_exccode != 0) & ~SR.EXL.
REQ-021 trap_req = int_take | exc_take, combinational, same cycle (zero latency).
REQ-022 Two-state FSM, RUN (EXL=0) and HANDLER (EXL=1); SR.EXL is the state bit.
REQ-023 RUN -> HANDLER on trap_req. At that edge: EXL=1; Cause.BD=m_bd; Cause.ExcCode = 0 if int_take, else m_exccode (interrupt has priority); EPC = m_bd ? m_pc-4 : m_pc, with bits [1:0] forced to 0.
REQ-024 HANDLER -> RUN on m_eret. At that edge EXL=0; eret_req=m_eret combinationally in the same cycle.
REQ-025 m_eret in RUN still asserts eret_req; EXL stays 0 and no other state changes.
REQ-026 In HANDLER, hw_int and nonzero m_exccode do not trigger trap_req and leave EPC, BD and ExcCode unchanged.
REQ-027 mtc0 writes: addr 12 writes IM, EXL and IE only; addr 14 writes EPC[31:2], with [1:0] forced to 0; addr 13, addr 15 and all other addresses are ignored.
REQ-028 trap_req and cp0_we in the same cycle: the trap update wins and the write is dropped.
REQ-029 m_eret and cp0_we to SR in the same cycle: EXL=0 wins; IM and IE take the written value.
REQ-030 trap_req and m_eret in the same cycle (RUN): the trap takes effect and eret_req is suppressed.
REQ-031 cp0_rdata: 12 SR, 13 Cause, 14 EPC, 15 PRID_VAL, others 0. A write is not visible until the next cycle.
REQ-032 EPC arithmetic is 32-bit modulo; m_pc=0 with m_bd=1 yields 32'hFFFF_FFFC.

Reset
REQ-033 While reset=0 at a clock edge: SR=0, Cause=0, EPC=0, and the FSM is in RUN.
REQ-034 trap_req and eret_req are 0 in any cycle where reset=0.
REQ-035 Reset asserted in HANDLER returns the FSM to RUN at the next edge; no pending interrupt is retained.

Structure
REQ-036 Shared package cp0_pkg holds: register addresses 12-15, field bit positions, HANDLER_PC default, ExcCode constants (Int 0, AdEL 4, AdES 5, Syscall 8, RI 10, Ov 12).
REQ-037 Single flat module; no sub-module is required.

Verification
REQ-038 Reset, then write SR=32'h0000_FC01, then hw_int=6'b000100 -> trap_req=1 that cycle; next cycle Cause.ExcCode=0, Cause.IP=6'b000100, EXL=1.
REQ-039 In RUN, m_exccode=5'd4, m_pc=32'h3008, m_bd=1 -> trap_req=1; EPC=32'h3004, Cause=32'h8000_0010.
REQ-040 In HANDLER, m_exccode=5'd8 -> trap_req=0 and EPC unchanged; then m_eret=1 -> eret_req=1, epc_out=EPC, EXL=0 next cycle.
REQ-041 SR.IE=1 and IM all ones, hw_int=6'b000001 together with m_exccode=5'd12 -> ExcCode=0 (interrupt wins).
REQ-042 cp0_we=1, cp0_addr=14, cp0_wdata=32'h3007 in the same cycle as m_exccode=5'd10 -> EPC=m_pc and the write is dropped.
REQ-043 reset=0 asserted while in HANDLER -> next cycle SR=0, EPC=0, and a later exception is taken again.
